// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcode encodings,
// the effective carry-in helper and the WIDTH/CHUNK elaboration check.
`ifndef PIPELINED_ADDER_PKG_SV
`define PIPELINED_ADDER_PKG_SV

// Stops elaboration when the operand width cannot be cut into whole slices.
`define PA_CHECK_MULTIPLE(w, c) \
  if (((w) % (c)) != 0) begin : g_width_check \
    $error("pipelined_adder: WIDTH must be a multiple of CHUNK"); \
  end

package pipelined_adder_pkg;

  // Opcode carried on the sub input and pipelined with each beat.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Subtraction is a + ~b + 1, so the external carry-in is ignored in sub mode.
  function automatic logic eff_cin(input logic op, input logic cin);
    return (op == OP_SUB) ? 1'b1 : cin;
  endfunction

  // Operand B as seen by the adders: inverted for subtraction.
  function automatic logic eff_b_bit(input logic op, input logic b_bit);
    return (op == OP_ADD) ? b_bit : ~b_bit;
  endfunction

endpackage

`endif

// File: rtl/adder_slice.sv
// CHUNK-bit combinational ripple adder. Besides the slice carry-out it exports
// the carry into the slice MSB so the last stage can form signed overflow.
module adder_slice #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             msb_cin
);

  // c[i] is the carry into bit i; c[CHUNK] is the carry out of the slice.
  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout    = c[CHUNK];
  assign msb_cin = c[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry add/subtract unit. One CHUNK-bit slice is resolved per
// stage with the carry registered in between; untouched upper operand slices
// ride along in skew registers and finished low result slices are carried
// forward so the whole sum lines up at the output register.
//
// Handshake: a beat moves on any edge where in_valid && in_ready; a result is
// taken on any edge where out_valid && out_ready. The whole pipe advances
// together (adv = !out_valid || out_ready) and in_ready is exactly adv, so a
// stalled output freezes every stage and nothing is dropped or duplicated.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  `PA_CHECK_MULTIPLE(WIDTH, CHUNK)

  logic             adv;
  logic             out_valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Result bits known once this stage has run, and operand bits still pending.
    localparam int LO_W = (k + 1) * CHUNK;
    localparam int HI_W = WIDTH - LO_W;

    logic             valid_i;
    logic             sub_i;
    logic             carry_i;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_raw;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_out;
    logic             c_msb;
    logic [LO_W-1:0]  lo_d;

    if (k == 0) begin : g_src
      // First stage works straight off the input beat.
      assign valid_i = in_valid;
      assign sub_i   = sub;
      assign carry_i = eff_cin(sub, cin);
      assign a_sl    = a[CHUNK-1:0];
      assign b_raw   = b[CHUNK-1:0];
      assign lo_d    = s_sl;
    end else begin : g_src
      // Later stages consume the lowest pending slice of the previous record.
      assign valid_i = g_stage[k-1].g_reg.q.valid;
      assign sub_i   = g_stage[k-1].g_reg.q.sub;
      assign carry_i = g_stage[k-1].g_reg.q.carry;
      assign a_sl    = g_stage[k-1].g_reg.q.a_hi[CHUNK-1:0];
      assign b_raw   = g_stage[k-1].g_reg.q.b_hi[CHUNK-1:0];
      assign lo_d    = {s_sl, g_stage[k-1].g_reg.q.sum_lo};
    end

    for (genvar j = 0; j < CHUNK; j++) begin : g_binv
      assign b_sl[j] = eff_b_bit(sub_i, b_raw[j]);
    end

    adder_slice #(
      .CHUNK (CHUNK)
    ) u_slice (
      .a       (a_sl),
      .b       (b_sl),
      .cin     (carry_i),
      .sum     (s_sl),
      .cout    (c_out),
      .msb_cin (c_msb)
    );

    if (k < STAGES - 1) begin : g_reg
      // Stage record: beat valid, opcode, slice carry, skewed operands, low result.
      typedef struct packed {
        logic            valid;
        logic            sub;
        logic            carry;
        logic [HI_W-1:0] a_hi;
        logic [HI_W-1:0] b_hi;
        logic [LO_W-1:0] sum_lo;
      } stage_t;

      stage_t          q;
      stage_t          d;
      logic [HI_W-1:0] a_rest;
      logic [HI_W-1:0] b_rest;
      logic            msb_unused;

      // Only the final slice's MSB carry matters for overflow.
      assign msb_unused = c_msb;

      if (k == 0) begin : g_rest
        assign a_rest = a[WIDTH-1:CHUNK];
        assign b_rest = b[WIDTH-1:CHUNK];
      end else begin : g_rest
        assign a_rest = g_stage[k-1].g_reg.q.a_hi[HI_W+CHUNK-1:CHUNK];
        assign b_rest = g_stage[k-1].g_reg.q.b_hi[HI_W+CHUNK-1:CHUNK];
      end

      // Assemble the record this stage hands to the next one.
      always_comb begin
        d        = '0;
        d.valid  = valid_i;
        d.sub    = sub_i;
        d.carry  = c_out;
        d.a_hi   = a_rest;
        d.b_hi   = b_rest;
        d.sum_lo = lo_d;
      end

      // Stage register: loads with the pipe, holds on a stall, clears on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q <= '0;
        end else if (adv) begin
          q <= d;
        end
      end
    end else begin : g_out
      // Output register: the valid bit follows the pipe; the result fields only
      // load for real beats so they keep the last result across bubbles.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid_q <= 1'b0;
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
        end else if (adv) begin
          out_valid_q <= valid_i;
          if (valid_i) begin
            sum_q  <= lo_d;
            cout_q <= c_out;
            ovf_q  <= c_msb ^ c_out;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed table at WIDTH=8/CHUNK=2, backpressure
// and mid-flight reset sequences, then a random run on the CHUNK=8 build.
module tb_pipelined_adder;

  logic clk;
  logic rst;

  logic       in_valid, in_ready, sub, cin, out_valid, out_ready, cout, ovf;
  logic [7:0] a, b, sum;

  logic       d1_in_valid, d1_in_ready, d1_sub, d1_cin, d1_out_valid, d1_out_ready;
  logic       d1_cout, d1_ovf;
  logic [7:0] d1_a, d1_b, d1_sum;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [9:0] exp_q[$];

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[11];

  pipelined_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready),
    .sub (sub), .a (a), .b (b), .cin (cin),
    .out_valid (out_valid), .out_ready (out_ready),
    .sum (sum), .cout (cout), .ovf (ovf)
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk (clk), .rst (rst),
    .in_valid (d1_in_valid), .in_ready (d1_in_ready),
    .sub (d1_sub), .a (d1_a), .b (d1_b), .cin (d1_cin),
    .out_valid (d1_out_valid), .out_ready (d1_out_ready),
    .sum (d1_sum), .cout (d1_cout), .ovf (d1_ovf)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
  endtask

  // Reference: {cout, ovf, sum} from plain integer arithmetic and sign rules.
  function automatic logic [9:0] model(input logic s, input logic [7:0] x,
                                       input logic [7:0] y, input logic ci);
    logic [7:0] yb;
    logic       c0;
    logic [8:0] full;
    logic       v;
    yb   = s ? ~y : y;
    c0   = s ? 1'b1 : ci;
    full = {1'b0, x} + {1'b0, yb} + {8'd0, c0};
    v    = (x[7] == yb[7]) && (full[7] != x[7]);
    return {full[8], v, full[7:0]};
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a negedge; issues one beat and checks latency and result.
  task automatic run_vec(input string tag, input vec_t v);
    int waited;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sub = v.sub; cin = v.cin; a = v.a; b = v.b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_latency"}, waited, 3);
    check({tag, "_sum"},  sum,  v.sum);
    check({tag, "_cout"}, cout, v.cout);
    check({tag, "_ovf"},  ovf,  v.ovf);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int issued, emitted, stale, d_issued, d_got, waited;
    logic [9:0] e;
    vec_t nv;

    vecs[0]  = '{1'b0, 1'b0, 8'h0F, 8'h01, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h07, 8'h05, 8'h02, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h12, 8'h34, 8'h47, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
    d1_in_valid = 1'b0; d1_out_ready = 1'b1; d1_sub = 1'b0; d1_cin = 1'b0;
    d1_a = '0; d1_b = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_sum",       sum, 0);
    check("reset_cout",      cout, 0);
    check("reset_ovf",       ovf, 0);
    check("reset_in_ready",  in_ready, 1);
    check("reset_d1_out_valid", d1_out_valid, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Bubbles after the last result must not disturb the held output fields.
    @(negedge clk);
    check("hold_out_valid", out_valid, 0);
    check("hold_sum", sum, 8'h0F);
    check("hold_cout", cout, 1);

    // Backpressure: 6 back-to-back beats, consumer stalls on cycles 5..8.
    issued = 0;
    emitted = 0;
    for (int cyc = 1; cyc <= 40 && emitted < 6; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 8);
      in_valid  = (issued < 6);
      sub = 1'b0; cin = 1'b0;
      a = 8'(issued);
      b = 8'(issued * 3);
      #1;
      if (out_valid && !out_ready) check("bp_in_ready_low", in_ready, 0);
      if (in_valid && in_ready) begin
        exp_q.push_back({2'b00, 8'(issued * 4)});
        issued++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("bp_result%0d", emitted), {cout, ovf, sum}, e);
        end
        emitted++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp_emitted", emitted, 6);
    check("bp_queue_empty", exp_q.size(), 0);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("bp_no_duplicate", stale, 0);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; sub = 1'b0; cin = 1'b0;
      a = 8'h40 + 8'(i); b = 8'h01;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("rst_no_stale", stale, 0);
    nv = '{1'b0, 1'b0, 8'h21, 8'h10, 8'h31, 1'b0, 1'b0};
    run_vec("post_rst", nv);
    @(negedge clk);

    // Degenerate build (CHUNK=8): latency 1.
    d1_in_valid = 1'b1; d1_out_ready = 1'b1; d1_sub = 1'b0; d1_cin = 1'b0;
    d1_a = 8'h7F; d1_b = 8'h01;
    @(posedge clk);
    @(negedge clk);
    d1_in_valid = 1'b0;
    waited = 0;
    while (!d1_out_valid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("d1_latency", waited, 0);
    check("d1_result", {d1_cout, d1_ovf, d1_sum}, {1'b0, 1'b1, 8'h80});
    @(negedge clk);

    // Random add/sub on the CHUNK=8 build with random handshakes.
    d_issued = 0;
    d_got = 0;
    for (int cyc = 0; cyc < 40000 && d_got < 10000; cyc++) begin
      d1_in_valid  = (d_issued < 10000) && ($urandom_range(0, 3) != 0);
      d1_out_ready = ($urandom_range(0, 3) != 0);
      d1_sub = 1'($urandom_range(0, 1));
      d1_cin = 1'($urandom_range(0, 1));
      d1_a   = 8'($urandom_range(0, 255));
      d1_b   = 8'($urandom_range(0, 255));
      #1;
      if (d1_in_valid && d1_in_ready) begin
        exp_q.push_back(model(d1_sub, d1_a, d1_b, d1_cin));
        d_issued++;
      end
      if (d1_out_valid && d1_out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_extra_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_result", {d1_cout, d1_ovf, d1_sum}, e);
        end
        d_got++;
      end
      @(negedge clk);
    end
    d1_in_valid = 1'b0;
    check("rand_count", d_got, 10000);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
